// File: rtl/lsu_pkg.sv
// Shared encodings, FSM states and defaults for the load/store unit.
package lsu_pkg;

  localparam int DEF_MEM_AW       = 10;
  localparam int DEF_READ_LATENCY = 1;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_RD_WAIT,
    ST_WR,
    ST_RMW_RD,
    ST_RMW_WAIT,
    ST_RMW_WR,
    ST_RESP
  } lsu_state_e;

  // Illegal size, misalignment, or any address bit above the memory's reach.
  function automatic logic is_fault(input logic [1:0] size, input logic [31:0] addr,
                                    input int unsigned aw);
    logic [31:0] upper;
    upper = addr >> (aw + 2);
    return (size == SZ_ILL) ||
           ((size == SZ_HALF) && addr[0]) ||
           ((size == SZ_WORD) && (addr[1:0] != 2'b00)) ||
           (upper != 32'd0);
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane extraction with sign/zero extension for loads, lane merge for sub-word stores.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [31:0] rdata_word,
  input  logic [1:0]  lane,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged_word
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel    = rdata_word[{lane, 3'b000} +: 8];
    half_sel    = lane[1] ? rdata_word[31:16] : rdata_word[15:0];
    load_data   = rdata_word;
    merged_word = wdata;
    case (size)
      SZ_BYTE: begin
        load_data   = {{24{byte_sel[7] & ~is_unsigned}}, byte_sel};
        merged_word = rdata_word;
        merged_word[{lane, 3'b000} +: 8] = wdata[7:0];
      end
      SZ_HALF: begin
        load_data   = {{16{half_sel[15] & ~is_unsigned}}, half_sel};
        merged_word = rdata_word;
        if (lane[1]) merged_word[31:16] = wdata[15:0];
        else         merged_word[15:0]  = wdata[15:0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store initiator for a single-port BRAM; sub-word
// stores are performed as read-modify-write of the full word.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_AW       = DEF_MEM_AW,
  parameter int READ_LATENCY = DEF_READ_LATENCY
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_read,
  output logic              mem_write,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  localparam int CW = 2;

  lsu_state_e        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [1:0]        size_q, size_d;
  logic [1:0]        lane_q, lane_d;
  logic              uns_q, uns_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic [MEM_AW-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic              resp_valid_q, resp_valid_d;
  logic              resp_err_q, resp_err_d;
  logic [31:0]       resp_rdata_q, resp_rdata_d;
  logic [31:0]       load_data, merged_word;
  logic              accept, wait_done;

  lsu_align u_align (
    .rdata_word  (mem_rdata),
    .lane        (lane_q),
    .size        (size_q),
    .is_unsigned (uns_q),
    .wdata       (wdata_q),
    .load_data   (load_data),
    .merged_word (merged_word)
  );

  assign req_ready = (state_q == ST_IDLE) && rst_n;
  assign accept    = req_valid && req_ready;
  assign wait_done = (cnt_q == CW'(READ_LATENCY - 1));

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    size_d       = size_q;
    lane_d       = lane_q;
    uns_d        = uns_q;
    wdata_d      = wdata_q;
    mem_read_d   = 1'b0;
    mem_write_d  = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    resp_valid_d = resp_valid_q;
    resp_err_d   = resp_err_q;
    resp_rdata_d = resp_rdata_q;
    case (state_q)
      ST_IDLE: if (accept) begin
        size_d  = req_size;
        lane_d  = req_addr[1:0];
        uns_d   = req_unsigned;
        wdata_d = req_wdata;
        if (is_fault(req_size, req_addr, MEM_AW)) begin
          state_d      = ST_RESP;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b1;
          resp_rdata_d = '0;
        end else begin
          mem_addr_d = req_addr[MEM_AW+1:2];
          mem_read_d = 1'b1;
          if (!req_write) begin
            state_d = ST_RD;
          end else if (req_size == SZ_WORD) begin
            state_d     = ST_WR;
            mem_write_d = 1'b1;
            mem_wdata_d = req_wdata;
          end else begin
            state_d = ST_RMW_RD;
          end
        end
      end
      ST_RD: begin
        state_d = ST_RD_WAIT;
        cnt_d   = '0;
      end
      ST_RD_WAIT: if (wait_done) begin
        state_d      = ST_RESP;
        resp_valid_d = 1'b1;
        resp_err_d   = 1'b0;
        resp_rdata_d = load_data;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      ST_WR, ST_RMW_WR: begin
        state_d      = ST_RESP;
        resp_valid_d = 1'b1;
        resp_err_d   = 1'b0;
        resp_rdata_d = '0;
      end
      ST_RMW_RD: begin
        state_d = ST_RMW_WAIT;
        cnt_d   = '0;
      end
      // Merge straight from the returning read data into the write word.
      ST_RMW_WAIT: if (wait_done) begin
        state_d     = ST_RMW_WR;
        mem_read_d  = 1'b1;
        mem_write_d = 1'b1;
        mem_wdata_d = merged_word;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      ST_RESP: if (resp_ready) begin
        state_d      = ST_IDLE;
        resp_valid_d = 1'b0;
        resp_err_d   = 1'b0;
        resp_rdata_d = '0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      size_q       <= SZ_BYTE;
      lane_q       <= '0;
      uns_q        <= 1'b0;
      wdata_q      <= '0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      size_q       <= size_d;
      lane_q       <= lane_d;
      uns_q        <= uns_d;
      wdata_q      <= wdata_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  assign mem_read   = mem_read_q;
  assign mem_write  = mem_write_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: three instances (read latency 1, 2, 3) each with
// its own BRAM model; checked against a byte-addressed reference memory.
module tb_load_store_unit;
  import lsu_pkg::*;

  localparam int AW = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        req_valid, req_write, req_unsigned, resp_ready, sweep_en;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;

  logic [2:0]         req_ready, resp_valid, resp_err, mem_read, mem_write;
  logic [2:0][31:0]   resp_rdata, mem_wdata, mem_rdata;
  logic [2:0][AW-1:0] mem_addr;

  int checks = 0;
  int errors = 0;
  logic [7:0] ref_bytes [4096];

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    logic [31:0] mem [1<<AW];
    logic [31:0] pipe [0:gi];
    logic        valid_in;
    assign valid_in = req_valid && ((gi == 0) || sweep_en);
    initial for (int i = 0; i < (1 << AW); i++) mem[i] = 32'h0;
    always @(posedge clk) begin
      if (mem_read[gi]) begin
        pipe[0] <= mem[mem_addr[gi]];
        if (mem_write[gi]) mem[mem_addr[gi]] <= mem_wdata[gi];
      end
      for (int s = 1; s <= gi; s++) pipe[s] <= pipe[s-1];
    end
    assign mem_rdata[gi] = pipe[gi];

    load_store_unit #(.MEM_AW(AW), .READ_LATENCY(gi + 1)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(valid_in), .req_ready(req_ready[gi]),
      .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid[gi]), .resp_ready(resp_ready),
      .resp_rdata(resp_rdata[gi]), .resp_err(resp_err[gi]),
      .mem_read(mem_read[gi]), .mem_write(mem_write[gi]),
      .mem_addr(mem_addr[gi]), .mem_wdata(mem_wdata[gi]), .mem_rdata(mem_rdata[gi])
    );
  end

  // Reference: little-endian byte memory of 4 KiB; everything else faults.
  task automatic model_access(input logic wr, input logic [1:0] sz, input logic uns,
                              input logic [31:0] addr, input logic [31:0] wd,
                              output logic exp_err, output logic [31:0] exp_rdata);
    int     nbytes;
    int     base;
    longint v;
    nbytes = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    base = int'(addr[11:0]);
    exp_rdata = 32'h0;
    exp_err = (sz == 2'b11) || ((sz == 2'b01) && (addr % 2 != 0)) ||
              ((sz == 2'b10) && (addr % 4 != 0)) || (addr >= 32'd4096);
    if (exp_err) return;
    if (wr) begin
      for (int i = 0; i < nbytes; i++) ref_bytes[base + i] = wd[8*i +: 8];
    end else begin
      v = 0;
      for (int i = 0; i < nbytes; i++) v = v | (longint'(ref_bytes[base + i]) << (8 * i));
      if (!uns && nbytes < 4 && v[8*nbytes-1]) v = v - (longint'(1) << (8 * nbytes));
      exp_rdata = v[31:0];
    end
  endtask

  // Issue one request on instance 0 with resp_ready high; returns the response
  // cycle (acceptance edge ends cycle 0) or -1 on timeout, plus strobe counts.
  task automatic run_req(input logic wr, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd,
                         output int lat, output logic [31:0] rdata, output logic err,
                         output int nrd, output int nwr, output logic [31:0] wlast);
    bit acc;
    acc = 0; lat = -1; rdata = '0; err = 1'b0; nrd = 0; nwr = 0; wlast = '0;
    @(posedge clk); #1;
    req_valid = 1; req_write = wr; req_size = sz; req_unsigned = uns;
    req_addr = addr; req_wdata = wd; resp_ready = 1;
    for (int i = 0; i < 20 && !acc; i++) begin
      @(negedge clk);
      acc = req_ready[0];
    end
    if (!acc) begin
      req_valid = 0;
      return;
    end
    @(posedge clk); #1;
    req_valid = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (mem_read[0]) nrd++;
      if (mem_write[0]) begin nwr++; wlast = mem_wdata[0]; end
      if (resp_valid[0]) begin
        lat = k; rdata = resp_rdata[0]; err = resp_err[0];
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 0; req_valid = 0; req_write = 0; req_size = 0; req_unsigned = 0;
    req_addr = 0; req_wdata = 0; resp_ready = 1; sweep_en = 0;
    repeat (3) @(negedge clk);
    checks++; if (req_ready[0] !== 1'b0) begin errors++; $display("FAIL reset_req_ready: got %b expected 0", req_ready[0]); end
    checks++; if (resp_valid[0] !== 1'b0 || resp_err[0] !== 1'b0) begin errors++; $display("FAIL reset_resp_flags: got %b%b expected 00", resp_valid[0], resp_err[0]); end
    checks++; if (mem_read[0] !== 1'b0 || mem_write[0] !== 1'b0) begin errors++; $display("FAIL reset_strobes: got %b%b expected 00", mem_read[0], mem_write[0]); end
    checks++; if (mem_addr[0] !== '0 || mem_wdata[0] !== '0 || resp_rdata[0] !== '0) begin errors++; $display("FAIL reset_data: addr %h wdata %h rdata %h expected all 0", mem_addr[0], mem_wdata[0], resp_rdata[0]); end
    rst_n = 1; #1;
    checks++; if (req_ready[0] !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b expected 1", req_ready[0]); end
    $display("test_reset done");
  endtask

  task automatic test_word_store_load;
    int lat, nrd, nwr; logic [31:0] rd, wl, erd; logic er, eer;
    model_access(1, SZ_WORD, 0, 32'h10, 32'hDEADBEEF, eer, erd);
    run_req(1, SZ_WORD, 0, 32'h10, 32'hDEADBEEF, lat, rd, er, nrd, nwr, wl);
    checks++; if (lat != 2 || er !== 1'b0) begin errors++; $display("FAIL word_store_resp: cycle %0d err %b expected cycle 2 err 0", lat, er); end
    checks++; if (nwr != 1 || wl !== 32'hDEADBEEF) begin errors++; $display("FAIL word_store_strobe: writes %0d data %h expected 1 deadbeef", nwr, wl); end
    model_access(0, SZ_WORD, 0, 32'h10, 0, eer, erd);
    run_req(0, SZ_WORD, 0, 32'h10, 0, lat, rd, er, nrd, nwr, wl);
    checks++; if (lat != 3 || rd !== erd) begin errors++; $display("FAIL word_load: cycle %0d data %h expected cycle 3 data %h", lat, rd, erd); end
    $display("test_word_store_load: load data %h at cycle %0d", rd, lat);
  endtask

  task automatic test_byte_rmw;
    int lat, nrd, nwr; logic [31:0] rd, wl, erd; logic er, eer;
    model_access(1, SZ_WORD, 0, 32'h20, 32'h11223344, eer, erd);
    run_req(1, SZ_WORD, 0, 32'h20, 32'h11223344, lat, rd, er, nrd, nwr, wl);
    model_access(1, SZ_BYTE, 0, 32'h21, 32'h000000AA, eer, erd);
    run_req(1, SZ_BYTE, 0, 32'h21, 32'h000000AA, lat, rd, er, nrd, nwr, wl);
    checks++; if (nwr != 1 || wl !== 32'h1122AA44) begin errors++; $display("FAIL rmw_write: writes %0d data %h expected 1 1122aa44", nwr, wl); end
    checks++; if (lat != 4 || er !== 1'b0) begin errors++; $display("FAIL rmw_resp: cycle %0d err %b expected cycle 4 err 0", lat, er); end
    model_access(0, SZ_BYTE, 0, 32'h21, 0, eer, erd);
    run_req(0, SZ_BYTE, 0, 32'h21, 0, lat, rd, er, nrd, nwr, wl);
    checks++; if (rd !== 32'hFFFFFFAA || rd !== erd) begin errors++; $display("FAIL signed_byte_load: got %h expected ffffffaa", rd); end
    run_req(0, SZ_BYTE, 1, 32'h21, 0, lat, rd, er, nrd, nwr, wl);
    checks++; if (rd !== 32'h000000AA) begin errors++; $display("FAIL unsigned_byte_load: got %h expected 000000aa", rd); end
    $display("test_byte_rmw: merged %h, unsigned load %h", wl, rd);
  endtask

  task automatic test_faults;
    logic [1:0]  sz [5] = '{SZ_HALF, SZ_WORD, SZ_WORD, SZ_BYTE, SZ_ILL};
    logic [31:0] ad [5] = '{32'h3, 32'h2, 32'h1000, 32'h1000, 32'h0};
    logic        wr [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    int lat, nrd, nwr; logic [31:0] rd, wl, erd; logic er, eer;
    for (int i = 0; i < 5; i++) begin
      model_access(wr[i], sz[i], 0, ad[i], 32'h5A5A5A5A, eer, erd);
      run_req(wr[i], sz[i], 0, ad[i], 32'h5A5A5A5A, lat, rd, er, nrd, nwr, wl);
      checks++; if (er !== 1'b1 || er !== eer) begin errors++; $display("FAIL fault_err[%0d]: got %b expected 1", i, er); end
      checks++; if (lat != 1 || rd !== 32'h0 || nrd != 0) begin errors++; $display("FAIL fault_timing[%0d]: cycle %0d rdata %h reads %0d expected 1 0 0", i, lat, rd, nrd); end
      $display("fault %0d: size %b addr %h err %b cycle %0d", i, sz[i], ad[i], er, lat);
    end
  endtask

  task automatic test_random;
    int lat, nrd, nwr, elat, enrd, enwr; logic [31:0] rd, wl, erd, a, wd; logic er, eer, w, u;
    logic [1:0] s;
    for (int t = 0; t < 40; t++) begin
      s = ($urandom_range(0, 15) == 0) ? SZ_ILL : 2'($urandom_range(0, 2));
      a = 32'($urandom_range(0, 63));
      if ($urandom_range(0, 3) != 0) a = (s == SZ_WORD) ? (a & ~32'h3) : (s == SZ_HALF) ? (a & ~32'h1) : a;
      if ($urandom_range(0, 9) == 0) a = a | (32'h1 << $urandom_range(12, 31));
      w = 1'($urandom_range(0, 1)); u = 1'($urandom_range(0, 1)); wd = $urandom;
      model_access(w, s, u, a, wd, eer, erd);
      elat = eer ? 1 : !w ? 3 : (s == SZ_WORD) ? 2 : 4;
      enrd = eer ? 0 : (w && s != SZ_WORD) ? 2 : 1;
      enwr = (eer || !w) ? 0 : 1;
      run_req(w, s, u, a, wd, lat, rd, er, nrd, nwr, wl);
      checks++; if (er !== eer) begin errors++; $display("FAIL rand_err[%0d]: got %b expected %b", t, er, eer); end
      checks++; if (rd !== erd) begin errors++; $display("FAIL rand_rdata[%0d]: got %h expected %h", t, rd, erd); end
      checks++; if (lat != elat) begin errors++; $display("FAIL rand_latency[%0d]: got %0d expected %0d", t, lat, elat); end
      checks++; if (nrd != enrd || nwr != enwr) begin errors++; $display("FAIL rand_strobes[%0d]: reads %0d writes %0d expected %0d %0d", t, nrd, nwr, enrd, enwr); end
      $display("rand %0d: wr %b size %b uns %b addr %h wdata %h -> err %b rdata %h cycle %0d", t, w, s, u, a, wd, er, rd, lat);
    end
  endtask

  task automatic test_backpressure;
    logic [31:0] erd; logic eer; bit acc; int seen;
    acc = 0; seen = -1;
    model_access(0, SZ_WORD, 0, 32'h10, 0, eer, erd);
    @(posedge clk); #1;
    req_valid = 1; req_write = 0; req_size = SZ_WORD; req_unsigned = 0; req_addr = 32'h10; resp_ready = 0;
    for (int i = 0; i < 20 && !acc; i++) begin @(negedge clk); acc = req_ready[0]; end
    @(posedge clk); #1;
    req_size = SZ_ILL; req_addr = 32'h0;
    for (int k = 1; k <= 10 && seen < 0; k++) begin
      @(negedge clk);
      if (resp_valid[0]) seen = k;
    end
    checks++; if (seen != 3) begin errors++; $display("FAIL bp_first_valid: cycle %0d expected 3", seen); end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++; if (resp_valid[0] !== 1'b1 || resp_rdata[0] !== erd) begin errors++; $display("FAIL bp_hold[%0d]: valid %b data %h expected 1 %h", k, resp_valid[0], resp_rdata[0], erd); end
      checks++; if (req_ready[0] !== 1'b0 || mem_read[0] !== 1'b0 || mem_write[0] !== 1'b0) begin errors++; $display("FAIL bp_quiet[%0d]: ready %b read %b write %b expected 000", k, req_ready[0], mem_read[0], mem_write[0]); end
    end
    resp_ready = 1;
    @(negedge clk);
    checks++; if (resp_valid[0] !== 1'b0 || req_ready[0] !== 1'b1) begin errors++; $display("FAIL bp_release: valid %b ready %b expected 0 1", resp_valid[0], req_ready[0]); end
    @(posedge clk); #1;
    req_valid = 0;
    @(negedge clk);
    checks++; if (resp_valid[0] !== 1'b1 || resp_err[0] !== 1'b1) begin errors++; $display("FAIL bp_next_accept: valid %b err %b expected 1 1", resp_valid[0], resp_err[0]); end
    $display("test_backpressure: held data %h, next request accepted after handshake", erd);
  endtask

  task automatic test_reset_mid_rmw;
    int lat, nrd, nwr, wr_seen; logic [31:0] rd, wl, erd; logic er, eer; bit acc;
    acc = 0; wr_seen = 0;
    model_access(1, SZ_WORD, 0, 32'h30, 32'h55667788, eer, erd);
    run_req(1, SZ_WORD, 0, 32'h30, 32'h55667788, lat, rd, er, nrd, nwr, wl);
    @(posedge clk); #1;
    req_valid = 1; req_write = 1; req_size = SZ_BYTE; req_addr = 32'h31; req_wdata = 32'h99; resp_ready = 1;
    for (int i = 0; i < 20 && !acc; i++) begin @(negedge clk); acc = req_ready[0]; end
    @(posedge clk); #1;
    req_valid = 0;
    @(posedge clk); #2;
    rst_n = 0; #1;
    checks++; if (mem_read[0] !== 1'b0 || mem_write[0] !== 1'b0 || resp_valid[0] !== 1'b0) begin errors++; $display("FAIL rst_mid_strobes: read %b write %b valid %b expected 000", mem_read[0], mem_write[0], resp_valid[0]); end
    repeat (3) begin @(negedge clk); if (mem_write[0]) wr_seen++; end
    rst_n = 1; #1;
    checks++; if (req_ready[0] !== 1'b1) begin errors++; $display("FAIL rst_mid_ready: got %b expected 1", req_ready[0]); end
    for (int k = 0; k < 4; k++) begin @(negedge clk); if (mem_write[0] || resp_valid[0]) wr_seen++; end
    checks++; if (wr_seen != 0) begin errors++; $display("FAIL rst_mid_no_write: got %0d strobes/responses expected 0", wr_seen); end
    model_access(0, SZ_WORD, 0, 32'h30, 0, eer, erd);
    run_req(0, SZ_WORD, 0, 32'h30, 0, lat, rd, er, nrd, nwr, wl);
    checks++; if (rd !== erd || rd !== 32'h55667788) begin errors++; $display("FAIL rst_mid_old_word: got %h expected 55667788", rd); end
    $display("test_reset_mid_rmw: word after reset %h", rd);
  endtask

  task automatic test_latency_sweep;
    int lat, nrd, nwr; logic [31:0] rd, wl, erd; logic er, eer; bit acc;
    int first [3]; logic [31:0] got [3];
    acc = 0;
    sweep_en = 1;
    model_access(1, SZ_WORD, 0, 32'h40, 32'hCAFEF00D, eer, erd);
    run_req(1, SZ_WORD, 0, 32'h40, 32'hCAFEF00D, lat, rd, er, nrd, nwr, wl);
    model_access(0, SZ_WORD, 0, 32'h40, 0, eer, erd);
    @(posedge clk); #1;
    req_valid = 1; req_write = 0; req_size = SZ_WORD; req_addr = 32'h40; resp_ready = 1;
    for (int i = 0; i < 20 && !acc; i++) begin @(negedge clk); acc = (req_ready == 3'b111); end
    @(posedge clk); #1;
    req_valid = 0;
    for (int i = 0; i < 3; i++) begin first[i] = -1; got[i] = '0; end
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++)
        if (resp_valid[i] && first[i] < 0) begin first[i] = k; got[i] = resp_rdata[i]; end
    end
    for (int i = 0; i < 3; i++) begin
      checks++; if (first[i] != 3 + i || got[i] !== erd) begin errors++; $display("FAIL sweep_rl%0d: cycle %0d data %h expected cycle %0d data %h", i + 1, first[i], got[i], 3 + i, erd); end
      $display("sweep READ_LATENCY=%0d: resp cycle %0d data %h", i + 1, first[i], got[i]);
    end
    sweep_en = 0;
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) ref_bytes[i] = 8'h0;
    test_reset();
    test_word_store_load();
    test_byte_rmw();
    test_faults();
    test_backpressure();
    test_random();
    test_reset_mid_rmw();
    test_latency_sweep();
    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Processor-side initiator for the single-port BRAM data memory. Accepts load/store requests from the execute stage over a valid/ready handshake, drives the memory's read-enable, write-enable, word address and write data, waits out the BRAM read latency, and returns sign- or zero-extended load data. The memory has one write enable covering the whole word, so byte and halfword stores are done as a read-modify-write.

## Interface
Parameters:
- MEM_AW, 10, memory word-address width; capacity is 2^MEM_AW words.
- READ_LATENCY, 1, BRAM read latency in cycles (legal values 1..3).

Ports:
- clk  in  1  system clock; everything samples on the rising edge.
- rst_n  in  1  asynchronous reset, active low.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request; high only in IDLE with rst_n high.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal.
- req_unsigned  in  1  loads only: zero-extend when 1, sign-extend when 0.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- resp_valid  out  1  response present.
- resp_ready  in  1  consumer accepts the response.
- resp_rdata  out  32  extended load data; 0 for stores and faults.
- resp_err  out  1  misaligned access, out-of-range access or illegal size.
- mem_read  out  1  memory enable; high for every memory access, reads and writes.
- mem_write  out  1  memory write enable; only ever high together with mem_read.
- mem_addr  out  MEM_AW  word address, req_addr[MEM_AW+1:2].
- mem_wdata  out  32  full-word write data.
- mem_rdata  in  32  memory read data.

## Operation
- A request is accepted on any edge where req_valid and req_ready are both high. The request is latched on that edge.
- Fault check happens at acceptance. The request faults if any of these hold:
  - req_size is 11;
  - a halfword request has req_addr[0] set;
  - a word request has req_addr[1:0] nonzero;
  - any of req_addr[31:MEM_AW+2] is nonzero.
- A faulting request goes straight to RESP with resp_err = 1. No memory strobe is issued.
- States and transitions:
  - IDLE: accepts a request. Goes to RD (load), WR (word store), RMW_RD (byte/half store), or RESP (fault).
  - RD: mem_read is high for one cycle, then the unit moves to RD_WAIT.
  - RD_WAIT: counts READ_LATENCY cycles, then captures mem_rdata. The addressed lane is extracted (byte lane = addr[1:0], half lane = addr[1]) and extended. Goes to RESP.
  - WR: mem_read and mem_write are both high for one cycle with mem_wdata = req_wdata. Goes to RESP.
  - RMW_RD: mem_read is high for one cycle, then RMW_WAIT.
  - RMW_WAIT: after READ_LATENCY cycles, the new byte/half is merged into the captured word. Goes to RMW_WR.
  - RMW_WR: write strobes for one cycle with the merged word. Goes to RESP.
  - RESP: resp_valid stays high and resp_* stays stable until resp_ready. On the handshake edge the unit returns to IDLE.
- Only one request is in flight at a time. req_ready is low from the acceptance edge until the unit is back in IDLE.
- While RESP is waiting for resp_ready, no new memory strobe is issued.

## Timing
- All memory-side outputs and resp_* are registered.
- Cycle numbering: the acceptance edge ends cycle 0.
- Word load: mem_read is high in cycle 1. Data arrives in cycle 1+READ_LATENCY. resp_valid rises in cycle 2+READ_LATENCY.
- Word store: strobes are high in cycle 1. resp_valid rises in cycle 2.
- Byte/half store: read in cycle 1, write strobes in cycle 2+READ_LATENCY, resp_valid in cycle 3+READ_LATENCY.
- Fault: resp_valid rises in cycle 1.
- If resp_ready is held high, the minimum gap between acceptances is the latency above plus one IDLE cycle.
- Reset state:
  - state = IDLE, counter = 0;
  - req_ready, resp_valid, resp_err, mem_read, mem_write = 0;
  - mem_addr, mem_wdata, resp_rdata = 0.
- Reset asserted mid-operation:
  - strobes drop immediately (asynchronous);
  - the in-flight request is discarded and no response is produced;
  - an RMW interrupted before RMW_WR leaves memory unmodified.
- Simultaneous resp_ready and req_valid in RESP: the response completes, and the new request is not accepted until the following IDLE cycle.

## Structure
- Package lsu_pkg holds:
  - the size encodings (SZ_BYTE, SZ_HALF, SZ_WORD);
  - the state enum;
  - default MEM_AW and READ_LATENCY constants.
- One combinational sub-module, lsu_align, does both lane extraction with sign/zero extension for loads and lane merging for RMW stores. The FSM lives in load_store_unit.

## Test plan
- Word store then word load: store 0xDEADBEEF at addr 0x010. Store response arrives at cycle 2 with resp_err = 0. The load of 0x010 returns 0xDEADBEEF at cycle 2+READ_LATENCY.
- Byte RMW: with memory word 0x11223344 at addr 0x020, store byte 0xAA at addr 0x021.
  - mem_write pulses once, with mem_wdata = 0x1122AA44.
  - A signed byte load of 0x021 then returns 0xFFFFFFAA.
  - An unsigned byte load of 0x021 returns 0x000000AA.
- Faults: each of these gives resp_err = 1 at cycle 1, resp_rdata = 0, and mem_read never high:
  - half load at addr 0x003;
  - word load at 0x002;
  - any access at 0x00001000 (MEM_AW = 10);
  - req_size = 11.
- Backpressure: hold resp_ready low for 5 cycles after a load. resp_valid and resp_rdata stay stable, req_ready stays 0, and no mem strobe is issued. Acceptance resumes one cycle after the handshake.
- Reset mid-RMW: drop rst_n during RMW_WAIT. mem_write never pulses, the old word is still readable after reset, and req_ready is high in the first cycle after release.
- Latency sweep: READ_LATENCY = 1, 2 and 3. Word-load resp_valid lands at cycle 3, 4 and 5 respectively.
